// File: rtl/serial_instr_rx_pkg.sv
// serial_instr_rx_pkg: shared FSM state encoding and default parameter values
package serial_instr_rx_pkg;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SAMPLE = 2'd1,
      ACK    = 2'd2,
      HOLD   = 2'd3
   } state_t;
   localparam int INSTR_W_DEF     = 10;
   localparam int PARITY_EN_DEF   = 1;
   localparam int TIMEOUT_CYC_DEF = 4096;
endpackage

// File: rtl/serial_instr_rx_sync2.sv
// sync2: two-flop synchroniser for asynchronous inputs, cleared by reset
module sync2 #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);
   logic [W-1:0] meta_q, sync_q;
   // two register stages absorb metastability before the bits reach the FSM
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end
   assign q_o = sync_q;
endmodule

// File: rtl/serial_instr_rx.sv
// serial_instr_rx: four-phase bit-serial instruction receiver with parity, backpressure and stall timeout
module serial_instr_rx
   import serial_instr_rx_pkg::*;
#(
   parameter int INSTR_W     = INSTR_W_DEF,
   parameter int PARITY_EN   = PARITY_EN_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               data_ready,
   input  logic               data_bit,
   output logic               data_ack,
   output logic [INSTR_W-1:0] instruction,
   output logic               instruction_valid,
   input  logic               instruction_ready,
   output logic               parity_err,
   output logic               timeout_err,
   output logic [15:0]        frame_count,
   output logic [1:0]         state
);
   localparam int N  = INSTR_W + PARITY_EN;
   localparam int CW = $clog2(N + 1);
   localparam int SW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

   logic               req_s, bit_s;
   state_t             state_q, state_d;
   logic [N-1:0]       sr_q, sr_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [SW-1:0]      stall_q, stall_d;
   logic               ack_q, ack_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic               perr_q, perr_d;
   logic [15:0]        fc_q, fc_d;
   logic               full, par_ok, partial, stalling, tmo;

   sync2 #(.W(2)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d_i   ({data_ready, data_bit}),
      .q_o   ({req_s, bit_s})
   );

   assign full     = cnt_q == CW'(N);
   assign par_ok   = (PARITY_EN == 0) || !(^sr_q);
   assign partial  = (cnt_q != '0) && !full;
   assign stalling = (state_q == ACK) || (state_q == IDLE && partial);
   assign tmo      = (TIMEOUT_CYC > 0) && stalling && (stall_q == SW'(TIMEOUT_CYC));

   // next-state logic: handshake sequencing, frame completion, consumer transfer and timeout abort
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      ack_d   = ack_q;
      instr_d = instr_q;
      perr_d  = 1'b0;
      fc_d    = fc_q;
      if (tmo) begin
         state_d = IDLE;
         sr_d    = '0;
         cnt_d   = '0;
         ack_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE:   state_d = req_s ? SAMPLE : IDLE;
            SAMPLE: begin
               sr_d    = {sr_q[N-2:0], bit_s};
               cnt_d   = cnt_q + 1'b1;
               ack_d   = 1'b1;
               state_d = ACK;
            end
            ACK: if (!req_s) begin
               ack_d = 1'b0;
               if (!full) begin
                  state_d = IDLE;
               end else if (par_ok) begin
                  state_d = HOLD;
                  instr_d = sr_q[N-1 -: INSTR_W];
               end else begin
                  state_d = IDLE;
                  perr_d  = 1'b1;
                  cnt_d   = '0;
                  sr_d    = '0;
               end
            end
            HOLD: if (instruction_ready) begin
               state_d = IDLE;
               cnt_d   = '0;
               fc_d    = fc_q + 16'd1;
            end
         endcase
      end
      stall_d = ((TIMEOUT_CYC > 0) && !tmo && stalling && state_d == state_q) ? stall_q + 1'b1 : '0;
   end

   // state and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         stall_q <= '0;
         ack_q   <= 1'b0;
         instr_q <= '0;
         perr_q  <= 1'b0;
         fc_q    <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         stall_q <= stall_d;
         ack_q   <= ack_d;
         instr_q <= instr_d;
         perr_q  <= perr_d;
         fc_q    <= fc_d;
      end
   end

   assign data_ack          = ack_q;
   assign instruction       = instr_q;
   assign instruction_valid = state_q == HOLD;
   assign parity_err        = perr_q;
   assign timeout_err       = tmo;
   assign frame_count       = fc_q;
   assign state             = state_q;
endmodule

// File: tb/tb_serial_instr_rx.sv
// tb_serial_instr_rx: randomized scoreboard bench for serial_instr_rx
module tb_serial_instr_rx;
   logic       clk, reset, data_ready, data_bit, data_ack;
   logic [9:0] instruction;
   logic       instruction_valid, instruction_ready, parity_err, timeout_err;
   logic [15:0] frame_count;
   logic [1:0] state;

   int total = 0, bad = 0;
   int n_perr = 0, n_tmo = 0, n_valid = 0, n_ackr = 0;
   int exp_perr = 0, exp_tmo = 0;
   int rdy_mode = 1;
   bit force_on = 0;
   bit fc_pend = 0;
   logic [15:0] exp_fc = 0;
   logic prev_ack = 0;
   logic [9:0] exp_q[$];

   serial_instr_rx #(.INSTR_W(10), .PARITY_EN(1), .TIMEOUT_CYC(16)) dut (
      .clk               (clk),
      .reset             (reset),
      .data_ready        (data_ready),
      .data_bit          (data_bit),
      .data_ack          (data_ack),
      .instruction       (instruction),
      .instruction_valid (instruction_valid),
      .instruction_ready (instruction_ready),
      .parity_err        (parity_err),
      .timeout_err       (timeout_err),
      .frame_count       (frame_count),
      .state             (state)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // consumer-ready driver, changes just after the rising edge
   initial begin
      instruction_ready = 1;
      forever begin
         @(posedge clk);
         #1;
         instruction_ready = (rdy_mode == 2) ? 1'($urandom) : (rdy_mode == 1);
      end
   end

   // monitor: scoreboard pops on transfers, counts pulses, tracks frame count
   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            exp_fc = 0;
            fc_pend = 0;
            prev_ack = 0;
         end else begin
            if (force_on) exp_fc = 16'hFFFF;
            if (fc_pend) begin
               chk("frame_count", frame_count, exp_fc);
               fc_pend = 0;
            end
            if (data_ack && !prev_ack) n_ackr++;
            prev_ack = data_ack;
            if (parity_err) n_perr++;
            if (timeout_err) n_tmo++;
            if (parity_err || timeout_err) chk("err_exclusive", parity_err & timeout_err, 0);
            if (instruction_valid) begin
               n_valid++;
               chk("hold_ack_low", data_ack, 0);
            end
            if (instruction_valid && instruction_ready) begin
               chk("queue_nonempty", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) chk("instruction", instruction, exp_q.pop_front());
               exp_fc = exp_fc + 16'd1;
               fc_pend = 1;
            end
         end
      end
   end

   task automatic send_bit(input logic b, input int gmax);
      int k;
      bit cl;
      data_bit = b;
      cl = !instruction_valid;
      data_ready = 1;
      k = 0;
      while (!data_ack && k < 300) begin
         @(posedge clk);
         #1;
         k++;
      end
      if (cl) chk("ack_latency", k, 4);
      else if (!data_ack) chk("ack_wait", data_ack, 1);
      @(negedge clk);
      data_ready = 0;
      k = 0;
      while (data_ack && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (data_ack) chk("ack_fall", data_ack, 0);
      repeat ($urandom_range(0, gmax)) @(negedge clk);
   endtask

   task automatic send_frame(input logic [9:0] p, input bit good, input int start);
      logic [10:0] f;
      f = {p, (^p) ^ !good};
      if (good) exp_q.push_back(p);
      else exp_perr++;
      for (int i = start; i < 11; i++) send_bit(f[10-i], 3);
   endtask

   initial begin
      int k, a0, v0, p0;
      logic [9:0] p;
      logic [10:0] f;
      reset = 1;
      data_ready = 0;
      data_bit = 0;
      repeat (3) @(negedge clk);
      chk("rst_state", state, 0);
      chk("rst_ack", data_ack, 0);
      chk("rst_valid", instruction_valid, 0);
      chk("rst_fc", frame_count, 0);
      chk("rst_instr", instruction, 0);
      chk("rst_errs", {parity_err, timeout_err}, 0);
      reset = 0;
      repeat (2) @(negedge clk);

      // clean frame
      a0 = n_ackr; v0 = n_valid;
      send_frame(10'h2A5, 1, 0);
      repeat (5) @(negedge clk);
      chk("clean_acks", n_ackr - a0, 11);
      chk("clean_valid_cycles", n_valid - v0, 1);
      chk("clean_fc", frame_count, 1);

      // parity error
      v0 = n_valid; p0 = n_perr;
      send_frame(10'h2A5, 0, 0);
      repeat (5) @(negedge clk);
      chk("perr_pulse", n_perr - p0, 1);
      chk("perr_no_valid", n_valid - v0, 0);
      chk("perr_fc", frame_count, 1);

      // backpressure with a second frame waiting
      rdy_mode = 0;
      send_frame(10'h155, 1, 0);
      chk("bp_valid", instruction_valid, 1);
      p = 10'h0F3;
      data_bit = p[9];
      data_ready = 1;
      a0 = n_ackr;
      repeat (50) @(negedge clk);
      chk("bp_no_ack", n_ackr - a0, 0);
      chk("bp_still_valid", instruction_valid, 1);
      rdy_mode = 1;
      send_frame(p, 1, 0);
      repeat (5) @(negedge clk);
      chk("bp_fc", frame_count, 3);

      // timeout after four bits
      for (int i = 0; i < 3; i++) send_bit(1'($urandom), 3);
      send_bit(1'($urandom), 0);
      k = 0;
      while (!timeout_err && k < 100) begin
         @(negedge clk);
         k++;
      end
      exp_tmo++;
      chk("timeout_delay", k, 16);
      send_frame(10'($urandom), 1, 0);

      // reset in the middle of bit 6, with data_ready held across reset
      for (int i = 0; i < 5; i++) send_bit(1'($urandom), 3);
      data_bit = 1;
      data_ready = 1;
      k = 0;
      while (!data_ack && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk("mid_ack_high", data_ack, 1);
      reset = 1;
      @(negedge clk);
      chk("mid_rst_ack", data_ack, 0);
      chk("mid_rst_state", state, 0);
      p = 10'($urandom);
      f = {p, ^p};
      data_bit = f[10];
      @(negedge clk);
      reset = 0;
      k = 0;
      while (!data_ack && k < 300) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("relaunch_latency", k, 4);
      @(negedge clk);
      data_ready = 0;
      while (data_ack) @(negedge clk);
      send_frame(p, 1, 1);
      repeat (5) @(negedge clk);
      chk("post_rst_fc", frame_count, 1);

      // frame counter wrap
      @(negedge clk);
      force_on = 1;
      force dut.fc_q = 16'hFFFF;
      repeat (2) @(negedge clk);
      release dut.fc_q;
      force_on = 0;
      @(negedge clk);
      chk("fc_preload", frame_count, 16'hFFFF);
      send_frame(10'($urandom), 1, 0);
      repeat (5) @(negedge clk);
      chk("fc_wrap", frame_count, 0);

      // randomized traffic with random backpressure
      rdy_mode = 2;
      for (int n = 0; n < 30; n++) send_frame(10'($urandom), $urandom_range(0, 4) != 0, 0);
      rdy_mode = 1;
      k = 0;
      while (exp_q.size() > 0 && k < 500) begin
         @(negedge clk);
         k++;
      end
      repeat (5) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      chk("parity_err_count", n_perr, exp_perr);
      chk("timeout_count", n_tmo, exp_tmo);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
